// File: rtl/instruction_fetch_scheduler.sv
// In-order fetch sequencer for the instruction loop buffer: credit-limited issue, stale-response discard, buffer write.
// Optional credit-stall counter is built only when MIST1032ISA_FETCH_SCHED_PERF_EN is defined.
module instruction_fetch_scheduler #(
  parameter int P_BUF_DEPTH       = 32,
  parameter int P_MAX_OUTSTANDING = 4,
  parameter int P_OUT_W           = 3
)(
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iEVENT_START,
  input  logic [31:0]        iEVENT_PC,
  input  logic               iBRANCH_REDIRECT,
  input  logic [31:0]        iBRANCH_ADDR,
  input  logic [5:0]         iBUF_COUNT,
  output logic               oMEM_REQ,
  output logic [31:0]        oMEM_ADDR,
  input  logic               iMEM_ACK,
  input  logic               iMEM_VALID,
  input  logic [31:0]        iMEM_DATA,
  output logic               oBUF_VALID,
  output logic [31:0]        oBUF_INST,
  output logic [31:0]        oBUF_PC,
  output logic [P_OUT_W-1:0] oOUTSTANDING,
  output logic [31:0]        oPERF_STALL_CNT
);

  localparam logic [1:0] L_IDLE  = 2'd0;
  localparam logic [1:0] L_RUN   = 2'd1;
  localparam logic [1:0] L_DRAIN = 2'd2;

  logic [1:0]         state_reg, state_next;
  logic [31:0]        fetch_pc_reg, resp_pc_reg;
  logic [P_OUT_W-1:0] outstanding_reg, outstanding_next;
  logic [P_OUT_W-1:0] discard_reg, discard_next;
  logic               buf_valid_reg;
  logic [31:0]        buf_inst_reg, buf_pc_reg;

  logic        redirect, mem_valid_eff, mem_req, accept, drop;
  logic [31:0] target;
  logic [7:0]  credit_sum;

  always_comb begin
    redirect      = iEVENT_START || (iBRANCH_REDIRECT && (state_reg != L_IDLE));
    target        = iEVENT_START ? {iEVENT_PC[31:2], 2'b00} : {iBRANCH_ADDR[31:2], 2'b00};
    // A response with nothing in flight is a protocol error and is ignored entirely.
    mem_valid_eff = iMEM_VALID && (outstanding_reg != '0);
    // The pending buffer write still counts against credit until the buffer reflects it.
    credit_sum    = 8'(iBUF_COUNT) + 8'(outstanding_reg) + 8'(buf_valid_reg);
    mem_req       = (state_reg == L_RUN) && !redirect
                    && (outstanding_reg < P_OUT_W'(P_MAX_OUTSTANDING))
                    && (credit_sum < 8'(P_BUF_DEPTH));
    accept        = mem_req && iMEM_ACK;
    drop          = mem_valid_eff && (discard_reg != '0);
    outstanding_next = outstanding_reg + P_OUT_W'(accept) - P_OUT_W'(mem_valid_eff);
    discard_next  = redirect ? outstanding_next : (discard_reg - P_OUT_W'(drop));

    state_next = state_reg;
    case (state_reg)
      L_IDLE:  if (iEVENT_START) state_next = L_RUN;
      L_RUN:   if (redirect && (outstanding_next != '0)) state_next = L_DRAIN;
      L_DRAIN: if (!redirect && (discard_next == '0)) state_next = L_RUN;
      default: state_next = L_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state_reg       <= L_IDLE;
      fetch_pc_reg    <= '0;
      resp_pc_reg     <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      buf_valid_reg   <= 1'b0;
      buf_inst_reg    <= '0;
      buf_pc_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      buf_valid_reg   <= 1'b0;
      if (redirect) begin
        fetch_pc_reg <= target;
        resp_pc_reg  <= target;
      end else begin
        if (accept) fetch_pc_reg <= fetch_pc_reg + 32'd4;
        if (mem_valid_eff && !drop) begin
          buf_valid_reg <= 1'b1;
          buf_inst_reg  <= iMEM_DATA;
          buf_pc_reg    <= resp_pc_reg;
          resp_pc_reg   <= resp_pc_reg + 32'd4;
        end
      end
    end
  end

`ifdef MIST1032ISA_FETCH_SCHED_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == L_RUN) && !redirect && !mem_req && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign oPERF_STALL_CNT = stall_cnt_reg;
`else
  assign oPERF_STALL_CNT = '0;
`endif

  assign oMEM_REQ     = mem_req;
  assign oMEM_ADDR    = fetch_pc_reg;
  assign oBUF_VALID   = buf_valid_reg;
  assign oBUF_INST    = buf_inst_reg;
  assign oBUF_PC      = buf_pc_reg;
  assign oOUTSTANDING = outstanding_reg;

endmodule

// File: tb/tb_instruction_fetch_scheduler.sv
// Bench for instruction_fetch_scheduler: directed vector table, hand-written corner sequences,
// and random traffic checked against a queue-of-requests reference model.
module tb_instruction_fetch_scheduler;

  logic        clk, rst_n;
  logic        ev, br, ack, valid;
  logic [31:0] ev_pc, br_addr, mem_data;
  logic [5:0]  cnt;
  logic        oMEM_REQ, oBUF_VALID;
  logic [31:0] oMEM_ADDR, oBUF_INST, oBUF_PC, oPERF_STALL_CNT;
  logic [2:0]  oOUTSTANDING;

  instruction_fetch_scheduler dut (
    .iCLOCK(clk), .inRESET(rst_n),
    .iEVENT_START(ev), .iEVENT_PC(ev_pc),
    .iBRANCH_REDIRECT(br), .iBRANCH_ADDR(br_addr),
    .iBUF_COUNT(cnt),
    .oMEM_REQ(oMEM_REQ), .oMEM_ADDR(oMEM_ADDR), .iMEM_ACK(ack),
    .iMEM_VALID(valid), .iMEM_DATA(mem_data),
    .oBUF_VALID(oBUF_VALID), .oBUF_INST(oBUF_INST), .oBUF_PC(oBUF_PC),
    .oOUTSTANDING(oOUTSTANDING), .oPERF_STALL_CNT(oPERF_STALL_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: every accepted request is a queue entry tagged live or stale.
  typedef struct { logic [31:0] pc; bit live; } req_t;
  req_t        mq[$];
  bit          m_running, m_draining, m_bv;
  logic [31:0] m_fetch, m_inst, m_pc, m_stall;

  logic        s_req, s_bv;
  logic [31:0] s_addr, s_inst, s_pc, s_perf;
  logic [2:0]  s_out;

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endfunction

  function void model_reset();
    mq.delete();
    m_running = 0; m_draining = 0; m_bv = 0;
    m_fetch = '0; m_inst = '0; m_pc = '0; m_stall = '0;
  endfunction

  // Sample and check outputs at the falling edge, advance the model, then return just after the rising edge.
  task automatic cycle();
    bit   redir, veff, exp_req, stale_left;
    req_t h;
    @(negedge clk);
    s_req = oMEM_REQ; s_addr = oMEM_ADDR; s_out = oOUTSTANDING;
    s_bv = oBUF_VALID; s_inst = oBUF_INST; s_pc = oBUF_PC; s_perf = oPERF_STALL_CNT;
    redir   = ev || (br && m_running);
    veff    = valid && (mq.size() != 0);
    exp_req = m_running && !m_draining && !redir && (mq.size() < 4)
              && ((int'(cnt) + mq.size() + int'(m_bv)) < 32);
    chk("mem_req", 32'(s_req), 32'(exp_req));
    chk("mem_addr", s_addr, m_fetch);
    chk("outstanding", 32'(s_out), 32'(mq.size()));
    chk("buf_valid", 32'(s_bv), 32'(m_bv));
    if (m_bv) begin
      chk("buf_inst", s_inst, m_inst);
      chk("buf_pc", s_pc, m_pc);
    end
`ifdef MIST1032ISA_FETCH_SCHED_PERF_EN
    chk("perf_cnt", s_perf, m_stall);
`else
    chk("perf_cnt", s_perf, 32'd0);
`endif
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_running && !m_draining && !redir && !exp_req && (m_stall != 32'hFFFF_FFFF)) m_stall++;
      m_bv = 0;
      if (veff) begin
        h = mq.pop_front();
        if (h.live && !redir) begin
          m_bv = 1; m_inst = mem_data; m_pc = h.pc;
        end
      end
      if (redir) begin
        foreach (mq[i]) mq[i].live = 0;
        m_draining = m_running && (m_draining || (mq.size() != 0));
        m_running  = 1;
        m_fetch    = (ev ? ev_pc : br_addr) & ~32'h3;
      end else begin
        if (exp_req && ack) begin
          h.pc = m_fetch; h.live = 1;
          mq.push_back(h);
          m_fetch = m_fetch + 32'd4;
        end
        if (m_draining) begin
          stale_left = 0;
          foreach (mq[i]) if (!mq[i].live) stale_left = 1;
          m_draining = stale_left;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Return every in-flight response (bounded by the model's queue), then let the DUT leave DRAIN.
  task automatic drain();
    ev = 0; br = 0; ack = 0;
    for (int k = 0; k < 16 && mq.size() != 0; k++) begin
      valid = 1; mem_data = $urandom;
      cycle();
    end
    valid = 0;
    cycle();
  endtask

  typedef struct {
    logic ev; logic [31:0] ev_pc; logic [5:0] cnt; logic ack; logic valid; logic [31:0] data;
    logic exp_req; logic [31:0] exp_addr; logic [2:0] exp_out;
    logic exp_bv; logic [31:0] exp_inst; logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[12];

  logic [31:0] p0;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h1003, 6'd0,  1'b1, 1'b0, 32'h0,         1'b0, 32'h0,    3'd0, 1'b0, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 32'h0,    6'd0,  1'b1, 1'b0, 32'h0,         1'b1, 32'h1000, 3'd0, 1'b0, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 32'h0,    6'd0,  1'b1, 1'b0, 32'h0,         1'b1, 32'h1004, 3'd1, 1'b0, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 32'h0,    6'd0,  1'b1, 1'b1, 32'hA0A0_0000, 1'b1, 32'h1008, 3'd2, 1'b0, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 32'h0,    6'd0,  1'b1, 1'b1, 32'hA1A1_0001, 1'b1, 32'h100C, 3'd2, 1'b1, 32'hA0A0_0000, 32'h1000};
    vecs[5]  = '{1'b0, 32'h0,    6'd0,  1'b0, 1'b1, 32'hA2A2_0002, 1'b1, 32'h1010, 3'd2, 1'b1, 32'hA1A1_0001, 32'h1004};
    vecs[6]  = '{1'b0, 32'h0,    6'd0,  1'b0, 1'b1, 32'hA3A3_0003, 1'b1, 32'h1010, 3'd1, 1'b1, 32'hA2A2_0002, 32'h1008};
    vecs[7]  = '{1'b0, 32'h0,    6'd0,  1'b0, 1'b0, 32'h0,         1'b1, 32'h1010, 3'd0, 1'b1, 32'hA3A3_0003, 32'h100C};
    vecs[8]  = '{1'b0, 32'h0,    6'd30, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1010, 3'd0, 1'b0, 32'h0,         32'h0};
    vecs[9]  = '{1'b0, 32'h0,    6'd30, 1'b1, 1'b0, 32'h0,         1'b1, 32'h1014, 3'd1, 1'b0, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 32'h0,    6'd30, 1'b1, 1'b0, 32'h0,         1'b0, 32'h1018, 3'd2, 1'b0, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 32'h0,    6'd32, 1'b1, 1'b0, 32'h0,         1'b0, 32'h1018, 3'd2, 1'b0, 32'h0,         32'h0};

    rst_n = 0; ev = 0; br = 0; ack = 0; valid = 0;
    ev_pc = '0; br_addr = '0; mem_data = '0; cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1;
    chk("rst_mem_req", 32'(oMEM_REQ), 32'd0);
    chk("rst_mem_addr", oMEM_ADDR, 32'd0);
    chk("rst_buf_valid", 32'(oBUF_VALID), 32'd0);
    chk("rst_buf_inst", oBUF_INST, 32'd0);
    chk("rst_buf_pc", oBUF_PC, 32'd0);
    chk("rst_outstanding", 32'(oOUTSTANDING), 32'd0);
    chk("rst_perf", oPERF_STALL_CNT, 32'd0);
    cycle();

    // Directed issue/response stream and credit ceiling.
    for (int i = 0; i < 12; i++) begin
      ev = vecs[i].ev; ev_pc = vecs[i].ev_pc; cnt = vecs[i].cnt;
      ack = vecs[i].ack; valid = vecs[i].valid; mem_data = vecs[i].data;
      cycle();
      chk("vec_req", 32'(s_req), 32'(vecs[i].exp_req));
      chk("vec_addr", s_addr, vecs[i].exp_addr);
      chk("vec_out", 32'(s_out), 32'(vecs[i].exp_out));
      chk("vec_bv", 32'(s_bv), 32'(vecs[i].exp_bv));
      if (vecs[i].exp_bv) begin
        chk("vec_inst", s_inst, vecs[i].exp_inst);
        chk("vec_pc", s_pc, vecs[i].exp_pc);
      end
      $display("vec %0d req=%0b addr=%h out=%0d bv=%0b pc=%h", i, s_req, s_addr, s_out, s_bv, s_pc);
    end
    ev = 0;

    // Fill to four outstanding, redirect, all four responses dropped, fetch resumes at target.
    cnt = 0; ack = 1; valid = 0;
    cycle(); cycle(); cycle();
    chk("max_out_req", 32'(s_req), 32'd0);
    chk("max_out_cnt", 32'(s_out), 32'd4);
    br = 1; br_addr = 32'h2000;
    cycle();
    chk("redir_req", 32'(s_req), 32'd0);
    br = 0;
    for (int k = 0; k < 4; k++) begin
      valid = 1; mem_data = $urandom;
      cycle();
      chk("drain_req", 32'(s_req), 32'd0);
      chk("drain_bv", 32'(s_bv), 32'd0);
    end
    valid = 0;
    cycle();
    chk("drop4_bv", 32'(s_bv), 32'd0);
    chk("resume_req", 32'(s_req), 32'd1);
    chk("resume_addr", s_addr, 32'h2000);
    valid = 1; mem_data = 32'hC0DE_0001;
    cycle();
    valid = 0; ack = 0;
    cycle();
    chk("first_after_redir_bv", 32'(s_bv), 32'd1);
    chk("first_after_redir_pc", s_pc, 32'h2000);
    chk("first_after_redir_inst", s_inst, 32'hC0DE_0001);
    $display("seq redirect done pc=%h", s_pc);

    // Event start beats a simultaneous branch redirect.
    ev = 1; ev_pc = 32'h3000; br = 1; br_addr = 32'h4000;
    cycle();
    ev = 0; br = 0;
    cycle();
    chk("prio_addr", s_addr, 32'h3000);
    drain();
    ack = 1;
    cycle();
    chk("prio_req", 32'(s_req), 32'd1);
    chk("prio_resume_addr", s_addr, 32'h3000);
    $display("seq priority done addr=%h", s_addr);

    // Fetch address wrap and simultaneous accept + return.
    ev = 1; ev_pc = 32'hFFFF_FFFF; ack = 0;
    cycle();
    drain();
    ack = 1;
    cycle();
    chk("wrap_req", 32'(s_req), 32'd1);
    chk("wrap_addr_hi", s_addr, 32'hFFFF_FFFC);
    valid = 1; mem_data = 32'h5A5A_5A5A;
    cycle();
    chk("wrap_addr_lo", s_addr, 32'h0);
    chk("wrap_out_before", 32'(s_out), 32'd1);
    valid = 0; ack = 0;
    cycle();
    chk("wrap_out_after", 32'(s_out), 32'd1);
    chk("wrap_bv_pc", s_pc, 32'hFFFF_FFFC);
    $display("seq wrap done pc=%h", s_pc);

    // Ten credit-stall cycles.
    drain();
    cnt = 32; ack = 0;
    cycle();
    p0 = s_perf;
    repeat (10) cycle();
`ifdef MIST1032ISA_FETCH_SCHED_PERF_EN
    chk("perf_delta", s_perf - p0, 32'd10);
`else
    chk("perf_delta", s_perf - p0, 32'd0);
`endif
    $display("seq stall done perf=%0d", s_perf);

    // Random traffic with one mid-run reset.
    cnt = 0;
    for (int n = 0; n < 400; n++) begin
      rst_n    = (n != 200);
      ev       = ($urandom % 40) == 0;
      ev_pc    = $urandom;
      br       = ($urandom % 25) == 0;
      br_addr  = $urandom;
      cnt      = (($urandom % 4) == 0) ? 6'($urandom_range(24, 32)) : 6'($urandom_range(0, 20));
      ack      = ($urandom % 10) < 7;
      valid    = (mq.size() != 0) ? 1'($urandom % 2) : (($urandom % 30) == 0);
      mem_data = $urandom;
      cycle();
    end
    rst_n = 1; ev = 0; br = 0; valid = 0; ack = 0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
